mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Multi-cycle main-memory responder. It is the target end of the CPU's memory request interface.
- It serves an instruction-side read port (IF stage / I-cache miss) and a data-side read/write port (MEM stage / D-cache miss) from one shared word array.
- It arbitrates between the two ports, holds exactly one outstanding transaction, and returns each response after a fixed, parameterised latency.
- It replaces the single-cycle memory1c instances when the pipeline moves to stall-on-miss memory.

Parameters:
- LATENCY, 4: cycles from the accept cycle to the response cycle; legal range 1..15.
- DEPTH_LOG2, 12: log2 of the number of 16-bit words in the array.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_req  in  1  instruction read request; held high until accepted.
- i_addr  in  16  instruction byte address.
- i_ready  out  1  instruction request accepted this cycle (combinational).
- i_rvalid  out  1  one-cycle pulse; i_rdata is valid.
- i_rdata  out  16  instruction read data.
- d_req  in  1  data request; held high until accepted.
- d_wr  in  1  1 = write, 0 = read; sampled at accept.
- d_addr  in  16  data byte address.
- d_wdata  in  16  write data; sampled at accept.
- d_ready  out  1  data request accepted this cycle (combinational).
- d_done  out  1  one-cycle pulse; data read or write complete.
- d_rdata  out  16  data read data; valid when d_done is high after a read.
- busy  out  1  high while a transaction is outstanding (state is not IDLE).

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - FSM goes to IDLE and the counter clears.
  - i_rvalid, d_done, busy = 0; i_rdata, d_rdata = 16'h0000.
  - i_ready, d_ready are forced to 0 while rst_n=0.
  - Array contents are not reset; they power up at 0.
- Addressing:
  - Word index = addr[DEPTH_LOG2:1].
  - addr[0] is ignored (misaligned accesses are treated as aligned).
  - Upper address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If d_req=1: d_ready=1; latch port=D, d_wr, word index and d_wdata.
  - Else if i_req=1: i_ready=1; latch port=I and word index.
  - D has fixed priority over I, because the MEM-stage instruction is older than the IF-stage one.
  - On an accept: if LATENCY=1, next state is RESP; otherwise next state is WAIT with cnt=LATENCY-2.
  - With no request, stay in IDLE. Ready is never asserted outside IDLE.
- WAIT:
  - If cnt==0, go to RESP; else decrement cnt.
  - New requests are ignored; the requester keeps req high.
- RESP (exactly one cycle), then always returns to IDLE:
  - I read: i_rdata <= mem[idx]; i_rvalid=1.
  - D read: d_rdata <= mem[idx]; d_done=1.
  - D write: mem[idx] <= wdata; d_done=1; d_rdata is unchanged.
  - Response outputs are registered, so the valid/done pulse and the data appear together in the cycle after the RESP edge.
  - Timing: accept at edge t gives valid/done visible in the cycle starting at edge t+LATENCY.
- Latency and throughput:
  - Fixed: LATENCY cycles from the accept cycle to the response cycle.
  - Throughput: at most one transaction per LATENCY+1 cycles.
  - The next accept can occur in the cycle in which valid/done is high.
- i_rdata and d_rdata hold their last values between responses.
- Ordering and coherency:
  - Transactions complete strictly in accept order.
  - The array is written only in RESP, so a read accepted after a write to the same word returns the new data.
- Simultaneous i_req and d_req in IDLE: D is accepted; I waits and is accepted at the next IDLE.
- Reset mid-transaction (WAIT or RESP):
  - The transaction is aborted; a pending write is discarded and the array is unchanged.
  - No valid/done pulse is produced.
  - Requesters must re-issue after reset.
- Inputs are sampled only at accept; changes to addr/wdata/wr after accept have no effect.

Test Plan:
- Reset values: hold rst_n=0 with i_req=d_req=1 -> all outputs 0, i_ready=d_ready=0. Release -> d_ready=1 in the first cycle.
- Single I read (LATENCY=4), mem[0x0010>>1] preloaded 0xBEEF: i_req with i_addr=0x0010 accepted at edge t -> i_rvalid=1 with i_rdata=0xBEEF in the cycle after edge t+4 only; busy high from t to t+4.
- D write then D read: write 0x1234 to 0x0040, then read 0x0040 -> d_done pulses twice; the second returns d_rdata=0x1234. Between them d_rdata is unchanged (still its previous value).
- Simultaneous requests: i_req=d_req=1 in IDLE -> d_ready first. The I request is accepted in the cycle d_done is high; i_rvalid follows LATENCY cycles later.
- Address rules: write 0xA5A5 to addr 0x0003, read 0x0002 -> 0xA5A5. Read 0x0002 + 2^(DEPTH_LOG2+1) -> 0xA5A5 (alias).
- Reset mid-op: write 0x5555 to 0x0080 is accepted; rst_n pulses low during WAIT -> no d_done; a subsequent read of 0x0080 returns the old value 0x0000.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory stages and mem_responder.
// The CPU side is the master; the responder is the slave.
interface mem_responder_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [15:0] i_rdata;

  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic        d_done;
  logic [15:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_done, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    output i_ready, i_rvalid, i_rdata, d_ready, d_done, d_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Multi-cycle main memory serving an instruction read port and a data read/write
// port from one word array; one outstanding transaction, fixed response latency.
module mem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]            state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  accept_d, accept_i;

  logic                  port_d;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0]           wdata;

  logic [15:0]           mem [2**DEPTH_LOG2];

  // Data side wins a tie: the MEM-stage instruction is older than the fetch.
  always_comb begin
    accept_d = rst_n && (state == IDLE) && bus.d_req;
    accept_i = rst_n && (state == IDLE) && bus.i_req && !bus.d_req;
  end

  assign bus.d_ready = accept_d;
  assign bus.i_ready = accept_i;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept_d || accept_i) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture; address bit 0 and bits above DEPTH_LOG2 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_d <= 1'b0;
      op_wr  <= 1'b0;
      idx    <= '0;
      wdata  <= '0;
    end else if (accept_d) begin
      port_d <= 1'b1;
      op_wr  <= bus.d_wr;
      idx    <= bus.d_addr[DEPTH_LOG2:1];
      wdata  <= bus.d_wdata;
    end else if (accept_i) begin
      port_d <= 1'b0;
      op_wr  <= 1'b0;
      idx    <= bus.i_addr[DEPTH_LOG2:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_rvalid <= 1'b0;
      bus.d_done   <= 1'b0;
      bus.i_rdata  <= '0;
      bus.d_rdata  <= '0;
    end else begin
      bus.i_rvalid <= (state == RESP) && !port_d;
      bus.d_done   <= (state == RESP) && port_d;
      if ((state == RESP) && !port_d)          bus.i_rdata <= mem[idx];
      if ((state == RESP) && port_d && !op_wr) bus.d_rdata <= mem[idx];
    end
  end

  // Array is written only from RESP, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if ((state == RESP) && port_d && op_wr) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with LATENCY=4, DEPTH_LOG2=12.
module tb_mem_responder;
  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   failures;

  mem_responder_if bus ();

  mem_responder #(.LATENCY(4), .DEPTH_LOG2(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one data access from IDLE and wait (bounded) for d_done.
  task automatic d_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    int got;
    got = 0;
    bus.d_req   = 1'b1;
    bus.d_wr    = wr;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    #1;
    chk("d_ready_at_idle", 16'(bus.d_ready), 16'h1);
    tick;
    bus.d_req   = 1'b0;
    bus.d_wr    = ~wr;
    bus.d_addr  = addr ^ 16'h0100;
    bus.d_wdata = ~wdata;
    for (int n = 1; n <= 12; n++) begin
      tick;
      if (bus.d_done) begin
        got = n;
        break;
      end
    end
    chk("d_latency", 16'(got), 16'd4);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n       = 1'b0;
    bus.i_req   = 1'b1;
    bus.i_addr  = 16'h0000;
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b0;
    bus.d_addr  = 16'h0000;
    bus.d_wdata = 16'h0000;

    // Reset with both requests held
    tick;
    tick;
    chk("rst_i_ready", 16'(bus.i_ready), 16'h0);
    chk("rst_d_ready", 16'(bus.d_ready), 16'h0);
    chk("rst_i_rvalid", 16'(bus.i_rvalid), 16'h0);
    chk("rst_d_done", 16'(bus.d_done), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_i_rdata", bus.i_rdata, 16'h0000);
    chk("rst_d_rdata", bus.d_rdata, 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("rel_d_ready", 16'(bus.d_ready), 16'h1);
    chk("rel_i_ready", 16'(bus.i_ready), 16'h0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick;

    // Preload and single instruction read
    d_access(1'b1, 16'h0010, 16'hBEEF);
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0010;
    #1;
    chk("i_ready_idle", 16'(bus.i_ready), 16'h1);
    tick;
    bus.i_req  = 1'b0;
    bus.i_addr = 16'h0ABC;
    for (int n = 1; n <= 3; n++) begin
      chk("i_wait_busy", 16'(busy), 16'h1);
      chk("i_wait_rvalid", 16'(bus.i_rvalid), 16'h0);
      tick;
    end
    chk("i_last_busy", 16'(busy), 16'h1);
    tick;
    chk("i_rvalid", 16'(bus.i_rvalid), 16'h1);
    chk("i_rdata", bus.i_rdata, 16'hBEEF);
    chk("i_resp_busy", 16'(busy), 16'h0);
    tick;
    chk("i_rvalid_pulse", 16'(bus.i_rvalid), 16'h0);
    chk("i_rdata_hold", bus.i_rdata, 16'hBEEF);

    // Data write then read of the same word
    d_access(1'b1, 16'h0040, 16'h1234);
    chk("wr_d_rdata_unchanged", bus.d_rdata, 16'h0000);
    d_access(1'b0, 16'h0040, 16'h0000);
    chk("rd_d_rdata", bus.d_rdata, 16'h1234);
    tick;
    chk("d_done_pulse", 16'(bus.d_done), 16'h0);

    // Simultaneous requests: data first, instruction accepted on d_done cycle
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0010;
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h0040;
    #1;
    chk("both_d_ready", 16'(bus.d_ready), 16'h1);
    chk("both_i_ready", 16'(bus.i_ready), 16'h0);
    tick;
    bus.d_req = 1'b0;
    chk("both_i_held_off", 16'(bus.i_ready), 16'h0);
    tick;
    tick;
    tick;
    tick;
    chk("both_d_done", 16'(bus.d_done), 16'h1);
    chk("both_d_rdata", bus.d_rdata, 16'h1234);
    chk("both_i_ready_late", 16'(bus.i_ready), 16'h1);
    tick;
    bus.i_req = 1'b0;
    chk("both_d_done_off", 16'(bus.d_done), 16'h0);
    tick;
    tick;
    tick;
    chk("both_i_rvalid_early", 16'(bus.i_rvalid), 16'h0);
    tick;
    chk("both_i_rvalid", 16'(bus.i_rvalid), 16'h1);
    chk("both_i_rdata", bus.i_rdata, 16'hBEEF);
    tick;

    // Address rules: odd address, aliasing
    d_access(1'b1, 16'h0003, 16'hA5A5);
    d_access(1'b0, 16'h0002, 16'h0000);
    chk("addr_misaligned", bus.d_rdata, 16'hA5A5);
    d_access(1'b0, 16'h0040, 16'h0000);
    chk("addr_other_word", bus.d_rdata, 16'h1234);
    d_access(1'b0, 16'h2002, 16'h0000);
    chk("addr_alias", bus.d_rdata, 16'hA5A5);

    // Reset during WAIT aborts a write
    d_access(1'b1, 16'h0080, 16'h0000);
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0080;
    bus.d_wdata = 16'h5555;
    tick;
    bus.d_req = 1'b0;
    tick;
    chk("abort_busy_pre", 16'(busy), 16'h1);
    rst_n     = 1'b0;
    bus.d_req = 1'b1;
    #1;
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_d_ready_forced", 16'(bus.d_ready), 16'h0);
    chk("abort_d_rdata", bus.d_rdata, 16'h0000);
    chk("abort_i_rdata", bus.i_rdata, 16'h0000);
    bus.d_req = 1'b0;
    tick;
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int n = 0; n < 6; n++) begin
        tick;
        if (bus.d_done) seen++;
      end
      chk("abort_no_done", 16'(seen), 16'd0);
    end
    d_access(1'b0, 16'h0080, 16'h0000);
    chk("abort_old_data", bus.d_rdata, 16'h0000);
    d_access(1'b0, 16'h0002, 16'h0000);
    chk("post_reset_array", bus.d_rdata, 16'hA5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
